// File: rtl/restoring_div_if.sv
// rtl/restoring_div_if.sv - request/result bundle for the 8-by-4 restoring divider
interface restoring_div_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    // requester side: issues operands, observes result and status
    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  div_by_zero
    );

    // divider side
    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output busy,
        output done,
        output div_by_zero
    );
endinterface

// File: rtl/restoring_div.sv
// rtl/restoring_div.sv - 8-bit by 4-bit unsigned restoring divider, one step per cycle; optional DIV_ZERO_DETECT_EN fast path
module restoring_div (
    input  logic            clk,
    input  logic            rst,
    restoring_div_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    // operands captured at acceptance; dividend shifts out MSB first
    logic [7:0] r_dvd;
    logic [3:0] r_dvs;
    // working partial remainder, quotient shift register and step counter
    logic [3:0] r_rem;
    logic [7:0] r_quo;
    logic [2:0] r_cnt;
    // architecturally visible results, only written at completion
    logic [7:0] r_quotient;
    logic [3:0] r_remainder;

    logic       w_accept;
    logic       w_last;
    logic [4:0] w_pr;
    logic       w_ge;
    logic [3:0] w_diff;
    logic [3:0] w_rem_next;
    logic [7:0] w_quo_next;

`ifdef DIV_ZERO_DETECT_EN
    logic       r_dbz;
    logic       w_zero;
`endif

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_cnt == 3'd7);

`ifdef DIV_ZERO_DETECT_EN
    assign w_zero   = (bus.divisor == 4'd0);
`endif

    // one restoring step: shift in next dividend bit, trial-subtract divisor.
    // When the trial succeeds the true difference is below the divisor, so
    // its low four bits (mod-16 subtraction) are exact.
    always_comb begin
        w_pr       = {r_rem, r_dvd[7]};
        w_ge       = (w_pr >= {1'b0, r_dvs});
        w_diff     = w_pr[3:0] - r_dvs;
        w_rem_next = w_ge ? w_diff : w_pr[3:0];
        w_quo_next = {r_quo[6:0], w_ge};
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic: DONE always lasts one cycle, start only matters in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DIV_ZERO_DETECT_EN
                    w_state_next = w_zero ? S_DONE : S_RUN;
`else
                    w_state_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // datapath: capture operands on accept, iterate in RUN, publish on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd       <= 8'd0;
            r_dvs       <= 4'd0;
            r_rem       <= 4'd0;
            r_quo       <= 8'd0;
            r_cnt       <= 3'd0;
            r_quotient  <= 8'd0;
            r_remainder <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dvd <= bus.dividend;
                        r_dvs <= bus.divisor;
                        r_rem <= 4'd0;
                        r_quo <= 8'd0;
                        r_cnt <= 3'd0;
`ifdef DIV_ZERO_DETECT_EN
                        // zero divisor skips iteration; publish the same
                        // values the full restoring walk would produce
                        if (w_zero) begin
                            r_quotient  <= 8'hFF;
                            r_remainder <= bus.dividend[3:0];
                        end
`endif
                    end
                end
                S_RUN: begin
                    r_dvd <= {r_dvd[6:0], 1'b0};
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_rem_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    // zero-divisor flag: decided at acceptance, held until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= w_zero;
        end
    end

    assign bus.div_by_zero = r_dbz;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);

endmodule

// File: doc/restoring_div.md
RESTORING_DIV -- requirements
Module: restoring_div

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 dividend  input  8  unsigned dividend; same width as the 4x4 multiplier product.
REQ-005 divisor  input  4  unsigned divisor.
REQ-006 quotient  output  8  unsigned quotient, registered.
REQ-007 remainder  output  4  unsigned remainder, registered.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 div_by_zero  output  1  set with done when divisor was 0; held until next accepted start.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 at an edge SHALL latch dividend and divisor, clear the partial remainder, clear the iteration counter and enter RUN.
REQ-013 busy SHALL equal 1 in RUN and DONE, and 0 in IDLE.
REQ-014 RUN SHALL perform one restoring step per cycle, MSB first, for exactly 8 cycles.
- Per step: form 5-bit partial remainder {rem[3:0], next dividend bit}.
- If it is >= divisor: subtract divisor and shift quotient bit 1.
- Otherwise: shift quotient bit 0.
REQ-015 The 3-bit iteration counter SHALL wrap from 7 to 0 on the 8th step, and RUN SHALL then go to DONE.
REQ-016 Latency: with start accepted at edge E0, steps SHALL occur at E1..E8, and done SHALL be 1 during the cycle after E8 only.
REQ-017 quotient and remainder SHALL update together at E8.
REQ-018 quotient and remainder SHALL hold their values until the next operation's E8 (or its fast-path completion) or until reset.
REQ-019 DONE SHALL return to IDLE at the next edge unconditionally.
REQ-020 A start arriving in DONE SHALL be ignored; a new start is accepted only from IDLE.
REQ-021 start asserted in RUN or DONE SHALL be ignored and SHALL NOT corrupt the latched operands.
REQ-022 Input changes after acceptance SHALL have no effect on the result.
REQ-023 Arithmetic SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.
REQ-024 With divisor == 0, the result SHALL be quotient=8'hFF and remainder=dividend[3:0] in all configurations.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, quotient=0, remainder=0, busy=0, done=0 and div_by_zero=0, and SHALL clear the counter and partial remainder.
REQ-026 rst has priority over start; reset during RUN SHALL abort the operation with no done pulse.
REQ-027 A start asserted in the same cycle as rst SHALL be dropped.

Configuration
REQ-028 Macro DIV_ZERO_DETECT_EN defined:
- A divisor of 0 at acceptance SHALL skip RUN and go directly to DONE.
- Result per REQ-024, div_by_zero=1, and done in the cycle after E0.
REQ-029 Macro DIV_ZERO_DETECT_EN undefined:
- div_by_zero SHALL be tied to 0.
- A divisor of 0 SHALL take the full 8-step path; the natural restoring result already equals REQ-024 values.
- done SHALL occur after E8.

Verification
REQ-030 Basic divide: dividend=54, divisor=9, start at E0 -> done after E8; quotient=6, remainder=0; busy high for E0..E9 only.
REQ-031 Sweep of products and non-multiples:
- 225/15 -> 15 r0.
- 100/7 -> 14 r2.
- 255/1 -> 255 r0.
- 130/10 -> 13 r0.
- 5/11 -> 0 r5.
- Each result SHALL match multiplier product + remainder.
REQ-032 Divide by zero: dividend=8'hA7, divisor=0 -> quotient=8'hFF, remainder=4'h7.
- With DIV_ZERO_DETECT_EN: div_by_zero=1 and done the cycle after E0.
- Without it: div_by_zero=0 and done after E8.
REQ-033 Busy protection: accept 54/9, then at E3 pulse start with 200/3 and change inputs -> result 6 r0; a single done pulse.
REQ-034 Reset mid-operation: rst at E4 -> next cycle IDLE, all outputs 0, no done. A new start 100/7 then completes to 14 r2.
REQ-035 Back-to-back: start held high continuously -> operations accepted only from IDLE, one every 10 cycles, each with correct result.
